// File: rtl/control_buscaminas.sv
// Minesweeper game sequencer: cursor, reveal/flag maps, iterative zero-region
// sweep over the 8x8 board and win/loss detection.
module control_buscaminas #(
    parameter int DIM       = 8,
    parameter int ANCHO_MIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [ANCHO_MIN-1:0]   num_minas,
    input  logic                   btn_arriba,
    input  logic                   btn_abajo,
    input  logic                   btn_izq,
    input  logic                   btn_der,
    input  logic                   btn_revelar,
    input  logic                   btn_bandera,
    output logic                   gen_inicio,
    input  logic                   gen_listo,
    output logic [2:0]             lec_fila,
    output logic [2:0]             lec_col,
    input  logic                   celda_mina,
    input  logic [2:0]             celda_ady,
    output logic [2:0]             cursor_fila,
    output logic [2:0]             cursor_col,
    output logic [DIM*DIM-1:0]     revelada,
    output logic [DIM*DIM-1:0]     bandera,
    output logic [6:0]             reveladas,
    output logic [2:0]             estado,
    output logic                   gano,
    output logic                   perdio
);

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        GENERA  = 3'd1,
        JUGANDO = 3'd2,
        REVELA  = 3'd3,
        BARRIDO = 3'd4,
        GANO    = 3'd5,
        PERDIO  = 3'd6
    } estado_t;

    estado_t                r_estado;
    logic [2:0]             r_cur_f;
    logic [2:0]             r_cur_c;
    logic [DIM*DIM-1:0]     r_revelada;
    logic [DIM*DIM-1:0]     r_bandera;
    logic [DIM*DIM-1:0]     r_cero;
    logic [6:0]             r_reveladas;
    logic                   r_gen_inicio;
    logic                   r_gano;
    logic                   r_perdio;
    logic [ANCHO_MIN-1:0]   r_num_minas;
    logic [5:0]             r_k;
    logic                   r_cambio;

    logic [5:0]             w_idx;
    logic [6:0]             w_objetivo;
    logic [6:0]             w_sig_cuenta;
    logic                   w_vecino_cero;
    logic                   w_actualiza;

    assign w_idx        = {r_cur_f, r_cur_c};
    assign w_objetivo   = 7'd64 - 7'(r_num_minas);
    assign w_sig_cuenta = r_reveladas + 7'd1;

    assign lec_fila = (r_estado == BARRIDO) ? r_k[5:3] : r_cur_f;
    assign lec_col  = (r_estado == BARRIDO) ? r_k[2:0] : r_cur_c;

    // Any in-bounds 8-neighbour of sweep cell k already known to be zero
    always_comb begin
        w_vecino_cero = 1'b0;
        for (int df = -1; df <= 1; df++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((df != 0 || dc != 0) &&
                    (int'(r_k[5:3]) + df) >= 0 && (int'(r_k[5:3]) + df) <= 7 &&
                    (int'(r_k[2:0]) + dc) >= 0 && (int'(r_k[2:0]) + dc) <= 7) begin
                    w_vecino_cero = w_vecino_cero |
                        r_cero[6'((int'(r_k[5:3]) + df) * 8 + int'(r_k[2:0]) + dc)];
                end
            end
        end
    end

    assign w_actualiza = (r_estado == BARRIDO) && !r_revelada[r_k] &&
                         !r_bandera[r_k] && !celda_mina && w_vecino_cero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado     <= REPOSO;
            r_cur_f      <= 3'd0;
            r_cur_c      <= 3'd0;
            r_revelada   <= '0;
            r_bandera    <= '0;
            r_cero       <= '0;
            r_reveladas  <= 7'd0;
            r_gen_inicio <= 1'b0;
            r_gano       <= 1'b0;
            r_perdio     <= 1'b0;
            r_num_minas  <= '0;
            r_k          <= 6'd0;
            r_cambio     <= 1'b0;
        end else begin
            r_gen_inicio <= 1'b0;
            if (inicio && r_estado != GENERA) begin
                r_num_minas  <= num_minas;
                r_revelada   <= '0;
                r_bandera    <= '0;
                r_cero       <= '0;
                r_reveladas  <= 7'd0;
                r_cur_f      <= 3'd0;
                r_cur_c      <= 3'd0;
                r_gano       <= 1'b0;
                r_perdio     <= 1'b0;
                r_k          <= 6'd0;
                r_cambio     <= 1'b0;
                r_gen_inicio <= 1'b1;
                r_estado     <= GENERA;
            end else begin
                unique case (r_estado)
                    GENERA: begin
                        // gen_listo is stale during the request cycle itself
                        if (!r_gen_inicio && gen_listo) r_estado <= JUGANDO;
                    end
                    JUGANDO: begin
                        if (btn_revelar) begin
                            if (!r_revelada[w_idx] && !r_bandera[w_idx])
                                r_estado <= REVELA;
                        end else if (btn_bandera) begin
                            if (!r_revelada[w_idx])
                                r_bandera[w_idx] <= ~r_bandera[w_idx];
                        end else if (btn_arriba) begin
                            if (r_cur_f != 3'd0) r_cur_f <= r_cur_f - 3'd1;
                        end else if (btn_abajo) begin
                            if (r_cur_f != 3'd7) r_cur_f <= r_cur_f + 3'd1;
                        end else if (btn_izq) begin
                            if (r_cur_c != 3'd0) r_cur_c <= r_cur_c - 3'd1;
                        end else if (btn_der) begin
                            if (r_cur_c != 3'd7) r_cur_c <= r_cur_c + 3'd1;
                        end
                    end
                    REVELA: begin
                        r_revelada[w_idx] <= 1'b1;
                        if (celda_mina) begin
                            r_perdio <= 1'b1;
                            r_estado <= PERDIO;
                        end else begin
                            r_reveladas <= w_sig_cuenta;
                            if (celda_ady == 3'd0) begin
                                r_cero[w_idx] <= 1'b1;
                                r_k           <= 6'd0;
                                r_cambio      <= 1'b0;
                                r_estado      <= BARRIDO;
                            end else if (w_sig_cuenta == w_objetivo) begin
                                r_gano   <= 1'b1;
                                r_estado <= GANO;
                            end else begin
                                r_estado <= JUGANDO;
                            end
                        end
                    end
                    BARRIDO: begin
                        if (w_actualiza) begin
                            r_revelada[r_k] <= 1'b1;
                            r_reveladas     <= w_sig_cuenta;
                            if (celda_ady == 3'd0) r_cero[r_k] <= 1'b1;
                            r_cambio <= 1'b1;
                        end
                        if (r_k == 6'd63) begin
                            if (r_cambio || w_actualiza) begin
                                r_k      <= 6'd0;
                                r_cambio <= 1'b0;
                            end else if (r_reveladas == w_objetivo) begin
                                r_gano   <= 1'b1;
                                r_estado <= GANO;
                            end else begin
                                r_estado <= JUGANDO;
                            end
                        end else begin
                            r_k <= r_k + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gen_inicio  = r_gen_inicio;
    assign cursor_fila = r_cur_f;
    assign cursor_col  = r_cur_c;
    assign revelada    = r_revelada;
    assign bandera     = r_bandera;
    assign reveladas   = r_reveladas;
    assign estado      = r_estado;
    assign gano        = r_gano;
    assign perdio      = r_perdio;

endmodule
